// File: rtl/rx_frame_seq_pkg.sv
// Shared constants and state type for the receive frame sequencer.
package rx_frame_seq_pkg;

    localparam int unsigned RXS_IDX_W   = 10;
    localparam int unsigned RXS_PRE_LEN = 512;
    localparam int unsigned RXS_SYM_LEN = 640;
    localparam int unsigned RXS_NSYM    = 10;
    localparam int unsigned RXS_SRCH_TO = 4096;
    localparam int unsigned RXS_SYM_W   = 4;
    localparam int unsigned RXS_CNT_W   = 16;

    typedef enum logic [2:0] {
        RXS_IDLE     = 3'd0,
        RXS_SEARCH   = 3'd1,
        RXS_ALIGN    = 3'd2,
        RXS_PREAMBLE = 3'd3,
        RXS_SIGPLD   = 3'd4
    } rxs_state_e;

endpackage

// File: rtl/rx_frame_seq_seg_counter.sv
// Loadable down-counter with a registered zero flag; decrements once per accepted sample.
module rx_frame_seq_seg_counter
    import rx_frame_seq_pkg::*;
#(
    parameter int unsigned W = RXS_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic         zero_q;

    // Load takes priority over decrement; zero flag tracks the value being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (clr_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            zero_q <= (load_val_i == '0);
        end else if (dec_i) begin
            cnt_q  <= cnt_q - W'(1);
            zero_q <= (cnt_q == W'(1));
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/rx_frame_seq.sv
// Frame sequencer: searches for the timing estimate, skips to the preamble and
// steers samples to the preamble or signal/payload path with symbol marking.
module rx_frame_seq
    import rx_frame_seq_pkg::*;
#(
    parameter int unsigned IDX_W   = RXS_IDX_W,
    parameter int unsigned PRE_LEN = RXS_PRE_LEN,
    parameter int unsigned SYM_LEN = RXS_SYM_LEN,
    parameter int unsigned NSYM    = RXS_NSYM,
    parameter int unsigned SRCH_TO = RXS_SRCH_TO,
    parameter int unsigned SYM_W   = RXS_SYM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             di_vld_i,
    input  logic [IDX_W-1:0] max_indx_i,
    input  logic             max_indx_vld_i,
    output logic             pre_sel_o,
    output logic             sp_sel_o,
    output logic             sym_start_o,
    output logic [SYM_W-1:0] sym_idx_o,
    output logic             frame_done_o,
    output logic             sync_err_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = RXS_CNT_W;

    rxs_state_e       state_q;
    logic [SYM_W-1:0] sym_q;
    logic             last_q;
    logic             pre_sel_q, sp_sel_q, sym_start_q, frame_done_q, sync_err_q, busy_q;
    logic [SYM_W-1:0] sym_idx_q;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt;

    // One counter serves every phase: it holds the samples remaining after the current one.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        unique case (state_q)
            RXS_IDLE: begin
                if (di_vld_i && en_i) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(SRCH_TO - 2);
                end
            end
            RXS_SEARCH: begin
                if (max_indx_vld_i) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = (max_indx_i != '0) ? CNT_W'(max_indx_i) - CNT_W'(1)
                                                      : CNT_W'(PRE_LEN - 1);
                end else if (di_vld_i) begin
                    cnt_dec = 1'b1;
                end
            end
            RXS_ALIGN: begin
                if (di_vld_i) begin
                    cnt_load     = cnt_zero;
                    cnt_dec      = !cnt_zero;
                    cnt_load_val = CNT_W'(PRE_LEN - 1);
                end
            end
            RXS_PREAMBLE, RXS_SIGPLD: begin
                if (di_vld_i) begin
                    cnt_load     = cnt_zero;
                    cnt_dec      = !cnt_zero;
                    cnt_load_val = CNT_W'(SYM_LEN - 1);
                end
            end
            default: ;
        endcase
    end

    rx_frame_seq_seg_counter #(.W(CNT_W)) u_seg_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // Frame FSM with registered strobes; frame_done trails the last sp_sel by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RXS_IDLE;
            sym_q        <= '0;
            last_q       <= 1'b0;
            pre_sel_q    <= 1'b0;
            sp_sel_q     <= 1'b0;
            sym_start_q  <= 1'b0;
            sym_idx_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pre_sel_q    <= 1'b0;
            sp_sel_q     <= 1'b0;
            sym_start_q  <= 1'b0;
            sym_idx_q    <= '0;
            sync_err_q   <= 1'b0;
            frame_done_q <= last_q;
            last_q       <= 1'b0;
            if (clr_i) begin
                state_q      <= RXS_IDLE;
                sym_q        <= '0;
                frame_done_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    RXS_IDLE: begin
                        if (di_vld_i && en_i) begin
                            state_q <= RXS_SEARCH;
                            busy_q  <= 1'b1;
                        end
                    end
                    RXS_SEARCH: begin
                        if (max_indx_vld_i) begin
                            state_q <= (max_indx_i != '0) ? RXS_ALIGN : RXS_PREAMBLE;
                        end else if (di_vld_i && cnt_zero) begin
                            state_q    <= RXS_IDLE;
                            busy_q     <= 1'b0;
                            sync_err_q <= 1'b1;
                        end
                    end
                    RXS_ALIGN: begin
                        if (di_vld_i && cnt_zero) state_q <= RXS_PREAMBLE;
                    end
                    RXS_PREAMBLE: begin
                        if (di_vld_i) begin
                            pre_sel_q <= 1'b1;
                            if (cnt_zero) begin
                                state_q <= RXS_SIGPLD;
                                sym_q   <= '0;
                            end
                        end
                    end
                    RXS_SIGPLD: begin
                        if (di_vld_i) begin
                            sp_sel_q    <= 1'b1;
                            sym_start_q <= (cnt == CNT_W'(SYM_LEN - 1));
                            sym_idx_q   <= sym_q;
                            if (cnt_zero) begin
                                if (sym_q == SYM_W'(NSYM - 1)) begin
                                    state_q <= RXS_IDLE;
                                    busy_q  <= 1'b0;
                                    last_q  <= 1'b1;
                                end else begin
                                    sym_q <= sym_q + SYM_W'(1);
                                end
                            end
                        end
                    end
                    default: state_q <= RXS_IDLE;
                endcase
            end
        end
    end

    assign pre_sel_o    = pre_sel_q;
    assign sp_sel_o     = sp_sel_q;
    assign sym_start_o  = sym_start_q;
    assign sym_idx_o    = sym_idx_q;
    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;
    assign busy_o       = busy_q;

endmodule
